gate_bist_seq: RTL
==================

# gate_bist_seq

Synthesizable stimulus-and-check sequencer for small combinational gate blocks such as the two-input AND test cell. On a start pulse it drives the gate's input pins with every input combination in ascending order, waits a settle interval for each, samples the gate output and compares it against the expected Boolean function. It sits directly around the gate: upstream as the input driver, downstream as the consumer of the gate's output. It reports done/pass, a mismatch count and the first failing vector.

## Interface
- N_IN, 2, number of gate inputs driven (1..8); vector space is 2^N_IN
- SETTLE_CYC, 4, cycles each vector is held before the output is sampled (>=1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; honored only in IDLE or DONE
- func_sel  in  2  expected function, latched on accepted start: 00 AND, 01 OR, 10 XOR, 11 NAND (reduction over all inputs)
- dut_in  out  N_IN  registered drive to the gate inputs (bit 0 = in_0, bit 1 = in_1, ...)
- dut_out  in  1  gate output, combinational from dut_in
- busy  out  1  high in SETTLE and CHECK
- done  out  1  high in DONE, held until next accepted start
- pass  out  1  valid when done; 1 iff err_cnt == 0
- err_cnt  out  N_IN+1  number of mismatching vectors in the last run
- fail_vec  out  N_IN  first mismatching vector of the run; 0 if none

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: dut_in=0, busy=0, done=0. start=1 -> SETTLE; dut_in<=0, settle counter<=SETTLE_CYC-1, err_cnt<=0, fail_vec<=0, func latched.
- SETTLE: counter decrements each cycle; counter==0 -> CHECK. dut_in stable throughout.
- CHECK (one cycle): exp = f(dut_in) per latched func; mismatch if dut_out != exp. On mismatch: err_cnt+1 (saturates at all-ones; cannot overflow since max is 2^N_IN); fail_vec<=dut_in if err_cnt==0 before the increment.
  - dut_in == 2^N_IN-1 -> DONE, dut_in held at last vector.
  - otherwise dut_in<=dut_in+1, counter<=SETTLE_CYC-1 -> SETTLE.
- DONE: done=1, busy=0, pass=(err_cnt==0); err_cnt/fail_vec held. start=1 -> restart exactly as from IDLE (done drops the next cycle).
- start while busy: ignored, no effect on the run.
- func_sel changes mid-run: ignored; only the latched value is used.
- dut_out sampled only on the CHECK clock edge; value in SETTLE is don't-care (glitches tolerated).

## Timing
- Reset (async assert, any state): state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0 immediately, no clock needed. Deassertion synchronous to clk; first start honored on the first edge with rst_n high.
- Per vector: SETTLE_CYC cycles SETTLE + 1 cycle CHECK = SETTLE_CYC+1 cycles held on dut_in.
- Start-to-done: done rises 2^N_IN x (SETTLE_CYC+1) cycles after the edge that accepted start (defaults: 20 cycles).
- busy rises the cycle after the accepting edge and falls in the same cycle done rises.
- pass, err_cnt, fail_vec stable from the cycle done rises until the next accepted start.
- Reset mid-run aborts; no partial results retained.

## Test plan
- Reset: hold rst_n=0 mid-run after 7 cycles -> all outputs 0 immediately; release, no start -> stays IDLE, dut_in=0.
- Correct AND gate, N_IN=2, SETTLE_CYC=4, func_sel=00 -> dut_in steps 00,01,10,11, 5 cycles each; done at cycle 20; pass=1, err_cnt=0, fail_vec=00.
- Gate output stuck at 0, func AND -> err_cnt=1, fail_vec=11, pass=0.
- Gate output stuck at 1, func AND -> err_cnt=3, fail_vec=00, pass=0.
- Correct AND gate, func_sel=01 (OR) -> mismatches at 01 and 10: err_cnt=2, fail_vec=01; second start from DONE with func_sel=00 -> results cleared, then pass=1, err_cnt=0.
- start pulsed at cycles 3 and 10 of a run, func_sel toggled mid-run -> run unaffected, done still at cycle 20 with the results of the originally latched function.

Source files
------------

// File: rtl/gate_bist_seq.sv
// Stimulus-and-check sequencer for small combinational gates: walks every input
// vector, waits a settle interval, and checks the gate output against a chosen function.
module gate_bist_seq #(
  parameter int unsigned N_IN       = 2,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      func_sel,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_vec
);

  localparam int unsigned CW = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        func_q, func_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic [N_IN:0]     err_cnt_q, err_cnt_d;
  logic [N_IN-1:0]   fail_vec_q, fail_vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              exp_out;

  always_comb begin
    case (func_q)
      2'b00:   exp_out = &dut_in_q;
      2'b01:   exp_out = |dut_in_q;
      2'b10:   exp_out = ^dut_in_q;
      default: exp_out = ~&dut_in_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    func_d     = func_q;
    dut_in_d   = dut_in_q;
    err_cnt_d  = err_cnt_q;
    fail_vec_d = fail_vec_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_SETTLE;
          cnt_d      = CNT_INIT;
          func_d     = func_sel;
          dut_in_d   = '0;
          err_cnt_d  = '0;
          fail_vec_d = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CHECK: begin
        if (dut_out != exp_out) begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          if (err_cnt_q == '0) fail_vec_d = dut_in_q;
        end
        if (dut_in_q == LAST_VEC) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_SETTLE;
          dut_in_d = dut_in_q + 1'b1;
          cnt_d    = CNT_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are derived from the next state so they are registered outputs.
    busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      func_q     <= '0;
      dut_in_q   <= '0;
      err_cnt_q  <= '0;
      fail_vec_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      func_q     <= func_d;
      dut_in_q   <= dut_in_d;
      err_cnt_q  <= err_cnt_d;
      fail_vec_q <= fail_vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign dut_in   = dut_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign fail_vec = fail_vec_q;

endmodule
